// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion and pointer sizing.
// Used by both the read-side and write-side pointer handlers.
package fifo_pkg;

    function automatic int ptr_bits(input int ptr_width);
        return ptr_width + 1;
    endfunction

    function automatic int depth_of(input int ptr_width);
        return 1 << ptr_width;
    endfunction

    // Operates on 32-bit zero-extended values; callers size-cast the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for Gray pointers crossing clock domains; 2-cycle latency.
// No flow control: samples every cycle, synchronous active-low reset to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_port.sv
// Async FIFO read port: pointer sync, empty/level, memory read issue, 2-entry FWFT output buffer.
// Write-to-m_valid 4 cycles; m_ready low stalls issue once buffer + in-flight read reach 2.
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH     = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [PTR_WIDTH:0]    g_wptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic [PTR_WIDTH-1:0]  raddr,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    level
);

    localparam int PW1 = ptr_bits(PTR_WIDTH);

    logic [PTR_WIDTH:0]    g_wptr_sync;
    logic [PTR_WIDTH:0]    b_wptr_sync;
    logic [PTR_WIDTH:0]    b_rptr_q, b_rptr_d;
    logic [PTR_WIDTH:0]    g_rptr_q, g_rptr_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [2:0]            occ;
    logic                  push;
    logic                  pop;

    sync_2ff #(
        .WIDTH (PW1)
    ) u_wptr_sync (
        .clk_i  (rclk),
        .rst_ni (rrst_n),
        .d_i    (g_wptr),
        .q_o    (g_wptr_sync)
    );

    assign b_wptr_sync  = PW1'(gray2bin(32'(g_wptr_sync)));
    assign empty        = (b_rptr_q == b_wptr_sync);
    assign level        = b_wptr_sync - b_rptr_q;
    assign almost_empty = (32'(level) <= 32'(AEMPTY_THRESH));

    assign m_valid = (count_q != 2'd0);
    assign m_data  = buf_q[0];
    assign pop     = m_valid & m_ready;
    assign push    = inflight_q;

    // Slots committed after this edge: buffered + returning word, minus the one leaving.
    assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign mem_ren = rrst_n & ~empty & (occ < 3'd2);

    assign raddr    = b_rptr_q[PTR_WIDTH-1:0];
    assign b_rptr_d = b_rptr_q + {{PTR_WIDTH{1'b0}}, mem_ren};
    assign g_rptr_d = PW1'(bin2gray(32'(b_rptr_d)));
    assign g_rptr   = g_rptr_q;

    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        count_d  = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) buf_d[0] = rdata;
                else                 buf_d[1] = rdata;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf_d[0] = buf_q[1];
                buf_d[1] = '0;
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // Head leaves while the returning word joins the tail.
                if (count_q == 2'd1) begin
                    buf_d[0] = rdata;
                end else begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            b_rptr_q   <= '0;
            g_rptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            b_rptr_q   <= b_rptr_d;
            g_rptr_q   <= g_rptr_d;
            count_q    <= count_d;
            inflight_q <= mem_ren;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

endmodule
